mult_seq_fsm: RTL and testbench
===============================

Name: mult_seq_fsm

Overview:
- Controller FSM that sequences the shared 4-entry register file and ALU to compute P = A * B by repeated addition.
- Same datapath and control interface as the Fibonacci controller: write address/enable, external load select, two read addresses, ALU opcode, and ALU zero_flag feedback.
- Sits beside the Fibonacci controller; a top-level mux selects which controller drives the datapath.

Parameters:
- SIZE, 3, ALU opcode width; register-file address width is SIZE-1 (4 registers).
- MAX_ITER, 15, iteration ceiling; used only when ITER_LIMIT_EN is defined.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  level request; sampled in IDLE.
- zero_flag  input  1  ALU result == 0; combinational from the current opcode and operands, valid in the same cycle.
- wrt_addr  output  SIZE-1  register-file write address.
- wrt_en  output  1  register-file write enable.
- load_data  output  1  1 = write port takes the external data bus; 0 = write port takes the ALU result.
- rd_addr1  output  SIZE-1  ALU operand A read address.
- rd_addr2  output  SIZE-1  ALU operand B read address.
- alu_opcode  output  SIZE  ALU operation.
- Done  output  1  result valid in R2.
- overflow  output  1  iteration limit hit; tied 0 without ITER_LIMIT_EN.

Behaviour:
- Register map: R0 = A (multiplicand), R1 = B (down-counter), R2 = P (accumulator), R3 unused.
- Opcodes: PASS=000 (out = operand A), ADD=001, SUB=010, DEC=011 (operand A - 1), ZERO=100 (out = 0).
- Moore machine. All outputs decode from the state register only. Async Rst forces IDLE, so all outputs go to 0 immediately, including wrt_en.
- Default values in every state unless listed: all outputs 0.
- IDLE: Start=1 at a rising edge -> LOAD_A.
- LOAD_A: load_data=1, wrt_en=1, wrt_addr=0 -> LOAD_B.
- LOAD_B: load_data=1, wrt_en=1, wrt_addr=1 -> CLR_P.
- CLR_P: alu_opcode=ZERO, wrt_en=1, wrt_addr=2 -> CHECK_B.
- CHECK_B: rd_addr1=1, alu_opcode=PASS.
  - zero_flag=1 -> DONE (B=0, so P=0).
  - otherwise -> ADD.
- ADD: rd_addr1=2, rd_addr2=0, alu_opcode=ADD, wrt_en=1, wrt_addr=2 -> DEC.
- DEC: rd_addr1=1, alu_opcode=DEC, wrt_en=1, wrt_addr=1.
  - zero_flag=1 (B-1 == 0) -> DONE.
  - otherwise -> ADD.
- DONE: Done=1, rd_addr1=2, alu_opcode=PASS (result visible on the ALU output).
  - Stays in DONE while Start=1.
  - Start=0 -> IDLE. This is a four-phase handshake; a new run needs Start to go low and then high again.
- Latency: counting from the edge that samples Start, Done first goes high in cycle 5+2B. For B=0 that is cycle 5.
- Start deasserting mid-run is ignored; the run completes.
- zero_flag is ignored in every state except CHECK_B and DEC.
- Reset mid-run abandons the run. Register-file contents are undefined to the controller afterwards.
- State encoding: binary, 3 bits, IDLE=0. An unused encoding goes to IDLE on the next edge.
- wrt_en and load_data are never both driven by the ALU path in the load states; load_data=1 only in LOAD_A and LOAD_B.

Optional Feature:
- Macro: ITER_LIMIT_EN.
- Defined:
  - An internal counter, cleared in CLR_P, increments on each ADD.
  - If the counter equals MAX_ITER in DEC and zero_flag=0, the FSM goes to DONE with overflow=1.
  - overflow holds until the FSM leaves DONE and is 0 in every other state.
  - Reset clears both the counter and overflow.
- Undefined: no counter exists, overflow is constant 0, and the loop runs until zero_flag.

Decomposition:
- Shared package rf_ctrl_pkg holds:
  - opcode constants (PASS, ADD, SUB, DEC, ZERO);
  - register indices (REG_A=0, REG_B=1, REG_P=2);
  - state encoding constants.
  - The Fibonacci controller reuses the opcodes and register indices from it.
- One sub-module, iter_limit_cnt: the MAX_ITER counter with clear, increment and hit outputs. It is instantiated only under ITER_LIMIT_EN.

Test Plan:
- Reset: Rst=1 mid-ADD -> outputs all 0 in the same cycle; state IDLE; Done=0 after release.
- Normal run, A=3, B=4, with the bench ALU/register-file model:
  - Done rises in cycle 13 after the Start edge;
  - R2=12;
  - exactly 4 ADD writes to addr 2 and 4 DEC writes to addr 1.
- B=0: zero_flag=1 in CHECK_B -> Done in cycle 5; R2=0; no ADD cycles.
- Handshake:
  - Start held high after Done -> Done stays 1 for 10 cycles and no re-run;
  - Start low for 1 cycle -> IDLE;
  - Start high again -> LOAD_A on the next edge.
- Ignored inputs: Start pulsed 0 during the ADD/DEC loop -> run unaffected; stray zero_flag=1 in LOAD_B -> no state deviation.
- With ITER_LIMIT_EN, MAX_ITER=15, B=20 -> after 15 ADDs, DONE with overflow=1; overflow=0 after returning to IDLE.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared constants for the register-file / ALU controllers (multiplier and
// Fibonacci): ALU opcodes, register indices and the multiplier state encoding.
package rf_ctrl_pkg;

    // ALU opcodes
    localparam logic [2:0] OP_PASS = 3'b000;  // out = operand A
    localparam logic [2:0] OP_ADD  = 3'b001;  // out = A + B
    localparam logic [2:0] OP_SUB  = 3'b010;  // out = A - B
    localparam logic [2:0] OP_DEC  = 3'b011;  // out = A - 1
    localparam logic [2:0] OP_ZERO = 3'b100;  // out = 0

    // Register indices
    localparam logic [1:0] REG_A = 2'd0;      // multiplicand
    localparam logic [1:0] REG_B = 2'd1;      // multiplier, counts down
    localparam logic [1:0] REG_P = 2'd2;      // product accumulator

    // Multiplier controller states, binary, IDLE = 0
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_CLR_P   = 3'd3,
        ST_CHECK_B = 3'd4,
        ST_ADD     = 3'd5,
        ST_DEC     = 3'd6,
        ST_DONE    = 3'd7
    } mult_state_e;

endpackage

// File: rtl/mult_seq_fsm_if.sv
// Control interface between a sequencing controller and the shared
// register file / ALU datapath.
interface mult_seq_fsm_if #(
    parameter int SIZE = 3
);
    logic            Start;
    logic            zero_flag;
    logic [SIZE-2:0] wrt_addr;
    logic            wrt_en;
    logic            load_data;
    logic [SIZE-2:0] rd_addr1;
    logic [SIZE-2:0] rd_addr2;
    logic [SIZE-1:0] alu_opcode;
    logic            Done;
    logic            overflow;

    // controller side
    modport master (
        input  Start,
        input  zero_flag,
        output wrt_addr,
        output wrt_en,
        output load_data,
        output rd_addr1,
        output rd_addr2,
        output alu_opcode,
        output Done,
        output overflow
    );

    // datapath / requester side
    modport slave (
        output Start,
        output zero_flag,
        input  wrt_addr,
        input  wrt_en,
        input  load_data,
        input  rd_addr1,
        input  rd_addr2,
        input  alu_opcode,
        input  Done,
        input  overflow
    );
endinterface

// File: rtl/mult_seq_fsm_iter_limit_cnt.sv
// Iteration counter for the multiplier loop: cleared before the loop,
// bumped once per ADD, flags when MAX_ITER additions have been done.
module iter_limit_cnt #(
    parameter int MAX_ITER = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);
    localparam int CW = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_ITER);

    logic [CW-1:0] cnt_q;

    // count ADDs; saturate at the limit so the compare can never wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // terminal-count compare
    always_comb begin
        hit = (cnt_q == LIMIT);
    end
endmodule

// File: rtl/mult_seq_fsm.sv
// Multiply-by-repeated-addition controller: drives the shared 4-entry
// register file and ALU to compute R2 = R0 * R1.
// Optional build macro ITER_LIMIT_EN caps the loop at MAX_ITER additions
// and reports the cap on overflow.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for Start
// LOAD_A   | write external bus into R0 (multiplicand)
// LOAD_B   | write external bus into R1 (multiplier)
// CLR_P    | R2 <= 0
// CHECK_B  | pass R1 through ALU, B == 0 ends immediately
// ADD      | R2 <= R2 + R0
// DEC      | R1 <= R1 - 1, loop again unless it reached 0
// DONE     | result in R2 shown on ALU output, wait Start low
module mult_seq_fsm
    import rf_ctrl_pkg::*;
#(
    parameter int SIZE     = 3,
    parameter int MAX_ITER = 15
) (
    input  logic           Clk,
    input  logic           Rst,
    mult_seq_fsm_if.master bus
);
    localparam int AW = SIZE - 1;

    mult_state_e state_q;
    mult_state_e state_d;
    logic        iter_hit;

    logic [AW-1:0]   wrt_addr;
    logic            wrt_en;
    logic            load_data;
    logic [AW-1:0]   rd_addr1;
    logic [AW-1:0]   rd_addr2;
    logic [SIZE-1:0] alu_opcode;
    logic            done;
    logic            overflow;

`ifdef ITER_LIMIT_EN
    logic ovf_q;

    iter_limit_cnt #(
        .MAX_ITER (MAX_ITER)
    ) u_iter_limit_cnt (
        .clk (Clk),
        .rst (Rst),
        .clr (state_q == ST_CLR_P),
        .inc (state_q == ST_ADD),
        .hit (iter_hit)
    );

    // remember that DONE was reached through the iteration cap
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_DEC) begin
            ovf_q <= iter_hit && !bus.zero_flag;
        end else if (state_q != ST_DONE) begin
            ovf_q <= 1'b0;
        end
    end

    // overflow is only meaningful while the result is presented
    always_comb begin
        overflow = ovf_q && (state_q == ST_DONE);
    end
`else
    // no cap: the loop always runs until B reaches zero
    always_comb begin
        iter_hit = 1'b0;
        overflow = 1'b0;
    end
`endif

    // state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode; zero_flag only matters in CHECK_B and DEC
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:    state_d = bus.Start ? ST_LOAD_A : ST_IDLE;
            ST_LOAD_A:  state_d = ST_LOAD_B;
            ST_LOAD_B:  state_d = ST_CLR_P;
            ST_CLR_P:   state_d = ST_CHECK_B;
            ST_CHECK_B: state_d = bus.zero_flag ? ST_DONE : ST_ADD;
            ST_ADD:     state_d = ST_DEC;
            ST_DEC: begin
                if (bus.zero_flag || iter_hit) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_DONE:    state_d = bus.Start ? ST_DONE : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Moore output decode from the state register alone
    always_comb begin
        wrt_addr   = '0;
        wrt_en     = 1'b0;
        load_data  = 1'b0;
        rd_addr1   = '0;
        rd_addr2   = '0;
        alu_opcode = '0;
        done       = 1'b0;
        case (state_q)
            ST_LOAD_A: begin
                load_data = 1'b1;
                wrt_en    = 1'b1;
                wrt_addr  = AW'(REG_A);
            end
            ST_LOAD_B: begin
                load_data = 1'b1;
                wrt_en    = 1'b1;
                wrt_addr  = AW'(REG_B);
            end
            ST_CLR_P: begin
                alu_opcode = SIZE'(OP_ZERO);
                wrt_en     = 1'b1;
                wrt_addr   = AW'(REG_P);
            end
            ST_CHECK_B: begin
                rd_addr1   = AW'(REG_B);
                alu_opcode = SIZE'(OP_PASS);
            end
            ST_ADD: begin
                rd_addr1   = AW'(REG_P);
                rd_addr2   = AW'(REG_A);
                alu_opcode = SIZE'(OP_ADD);
                wrt_en     = 1'b1;
                wrt_addr   = AW'(REG_P);
            end
            ST_DEC: begin
                rd_addr1   = AW'(REG_B);
                alu_opcode = SIZE'(OP_DEC);
                wrt_en     = 1'b1;
                wrt_addr   = AW'(REG_B);
            end
            ST_DONE: begin
                done       = 1'b1;
                rd_addr1   = AW'(REG_P);
                alu_opcode = SIZE'(OP_PASS);
            end
            default: begin
            end
        endcase
    end

    // drive the interface
    always_comb begin
        bus.wrt_addr   = wrt_addr;
        bus.wrt_en     = wrt_en;
        bus.load_data  = load_data;
        bus.rd_addr1   = rd_addr1;
        bus.rd_addr2   = rd_addr2;
        bus.alu_opcode = alu_opcode;
        bus.Done       = done;
        bus.overflow   = overflow;
    end
endmodule

// File: tb/tb_mult_seq_fsm.sv
// Bench for mult_seq_fsm: hangs a register file and ALU on the controller,
// runs directed and random multiplications and compares product, latency,
// write counts and handshake behaviour with an arithmetic reference.
module tb_mult_seq_fsm;
    localparam int MAX_IT = 15;

    logic clk;
    logic rst;
    logic zf_force;
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic [7:0] rf [4];
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] alu_out;
    logic [7:0] ext_data;

    int checks = 0;
    int errors = 0;

    mult_seq_fsm_if #(.SIZE(3)) bus ();

    mult_seq_fsm #(
        .SIZE     (3),
        .MAX_ITER (MAX_IT)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datapath harness: ALU, external data bus, register file
    always_comb begin
        op_a = rf[bus.rd_addr1];
        op_b = rf[bus.rd_addr2];
        case (bus.alu_opcode)
            3'b000:  alu_out = op_a;
            3'b001:  alu_out = op_a + op_b;
            3'b010:  alu_out = op_a - op_b;
            3'b011:  alu_out = op_a - 8'd1;
            3'b100:  alu_out = 8'd0;
            default: alu_out = 8'd0;
        endcase
        ext_data = (bus.wrt_addr == 2'd0) ? a_val : b_val;
    end

    assign bus.zero_flag = (alu_out == 8'd0) || zf_force;

    always @(posedge clk) begin
        if (bus.wrt_en) rf[bus.wrt_addr] <= bus.load_data ? ext_data : alu_out;
    end

    function automatic logic [12:0] outs();
        return {bus.wrt_addr, bus.wrt_en, bus.load_data, bus.rd_addr1,
                bus.rd_addr2, bus.alu_opcode, bus.Done, bus.overflow};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one complete multiplication with a four-phase Start handshake
    task automatic run(input logic [7:0] a, input logic [7:0] b,
                       input bit pulse_start, input bit stray_zf, input bit hold_check);
        int n;
        int n_add;
        int n_dec;
        int b_eff;
        bit ovf_exp;
        logic [7:0] p_exp;
        n = 0;
        n_add = 0;
        n_dec = 0;
        ovf_exp = 1'b0;
        b_eff = int'(b);
`ifdef ITER_LIMIT_EN
        if (b_eff > MAX_IT) begin
            b_eff = MAX_IT;
            ovf_exp = 1'b1;
        end
`endif
        p_exp = 8'(int'(a) * b_eff);

        @(negedge clk);
        a_val = a;
        b_val = b;
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        chk("load_a_outputs", 32'(outs()), 32'({2'd0, 1'b1, 1'b1, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0}));
        while (!bus.Done && n < 200) begin
            if (bus.wrt_en && !bus.load_data && bus.wrt_addr == 2'd2 && bus.alu_opcode == 3'b001) n_add++;
            if (bus.wrt_en && !bus.load_data && bus.wrt_addr == 2'd1 && bus.alu_opcode == 3'b011) n_dec++;
            if (bus.load_data && !(n == 0 || n == 1)) n = 1000;
            @(posedge clk);
            #1;
            n++;
            if (stray_zf) zf_force = (n == 1);
            if (pulse_start) bus.Start = (n != 5);
        end
        zf_force = 1'b0;
        bus.Start = 1'b1;
        chk("done_latency", 32'(n), 32'(4 + 2 * b_eff));
        chk("product_r2", 32'(rf[2]), 32'(p_exp));
        chk("alu_shows_p", 32'(alu_out), 32'(p_exp));
        chk("add_writes", 32'(n_add), 32'(b_eff));
        chk("dec_writes", 32'(n_dec), 32'(b_eff));
        chk("overflow_in_done", 32'(bus.overflow), 32'(ovf_exp));

        if (hold_check) begin
            int bad;
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (!(bus.Done === 1'b1 && bus.wrt_en === 1'b0)) bad++;
            end
            chk("done_held_no_rerun", 32'(bad), 32'd0);
        end

        @(negedge clk);
        bus.Start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_release", 32'(outs()), 32'd0);
        chk("idle_state", 32'(dut.state_q), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        zf_force = 1'b0;
        bus.Start = 1'b0;
        a_val = 8'd0;
        b_val = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(outs()), 32'd0);
        chk("reset_state", 32'(dut.state_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_no_start", 32'(outs()), 32'd0);

        // directed: 3 * 4, then B = 0
        run(8'd3, 8'd4, 1'b0, 1'b0, 1'b0);
        run(8'd7, 8'd0, 1'b0, 1'b0, 1'b0);

        // Start held after Done, then immediate re-run
        run(8'd5, 8'd6, 1'b0, 1'b0, 1'b1);
        run(8'd2, 8'd3, 1'b0, 1'b0, 1'b0);

        // Start glitch in the loop and stray zero_flag in LOAD_B
        run(8'd6, 8'd5, 1'b1, 1'b1, 1'b0);

        // random operands
        for (int k = 0; k < 6; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 15));
            rb = 8'($urandom_range(0, 12));
            run(ra, rb, (rb >= 8'd3) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1, 1'b0);
        end

        // reset in the middle of ADD
        @(negedge clk);
        a_val = 8'd4;
        b_val = 8'd5;
        bus.Start = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_in_add", 32'(dut.state_q), 32'd5);
        rst = 1'b1;
        #1;
        chk("midrun_reset_outputs", 32'(outs()), 32'd0);
        chk("midrun_reset_state", 32'(dut.state_q), 32'd0);
        bus.Start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_done", 32'(bus.Done), 32'd0);
        chk("post_reset_state", 32'(dut.state_q), 32'd0);

        run(8'd4, 8'd2, 1'b0, 1'b0, 1'b0);

`ifdef ITER_LIMIT_EN
        run(8'd3, 8'd20, 1'b0, 1'b0, 1'b0);
        chk("overflow_cleared_idle", 32'(bus.overflow), 32'd0);
        run(8'd2, 8'd15, 1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
